seq_3bit_checker: RTL and testbench

SEQ_3BIT_CHECKER -- requirements
Module: seq_3bit_checker

---
 rtl/seq_3bit_checker.sv | 98 +++++++++
 tb/tb_seq_3bit_checker.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seq_3bit_checker.sv
// seq_3bit_checker: lock-and-track checker for the cyclic code 000-100-111-010-011.
// Optional error counter enabled by defining SEQ_CHK_ERRCNT_EN.
module seq_3bit_checker #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       code,
    input  logic             code_valid,
    output logic             locked,
    output logic [2:0]       index,
    output logic             wrap,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);
    localparam logic [0:0] S_UNLOCKED = 1'b0;
    localparam logic [0:0] S_LOCKED   = 1'b1;

    logic [0:0] state_q, state_d;
    logic [2:0] exp_q, exp_d, index_q, index_d;
    logic       wrap_q, wrap_d, err_q, err_d;
    logic [2:0] succ, ord;

    assign succ = code == 3'b000 ? 3'b100 :
                  code == 3'b100 ? 3'b111 :
                  code == 3'b111 ? 3'b010 :
                  code == 3'b010 ? 3'b011 : 3'b000;
    assign ord  = code == 3'b100 ? 3'd1 :
                  code == 3'b111 ? 3'd2 :
                  code == 3'b010 ? 3'd3 :
                  code == 3'b011 ? 3'd4 : 3'd0;

    // exp_q only ever holds legal codes, so illegal inputs can never match
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        index_d = index_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (code_valid) begin
            if (state_q == S_UNLOCKED) begin
                if (code == 3'b000) begin
                    state_d = S_LOCKED;
                    index_d = 3'd0;
                    exp_d   = 3'b100;
                end
            end else if (code == exp_q) begin
                index_d = ord;
                exp_d   = succ;
                wrap_d  = code == 3'b011;
            end else if (code == 3'b000) begin
                err_d   = 1'b1;
                index_d = 3'd0;
                exp_d   = 3'b100;
            end else begin
                err_d   = 1'b1;
                state_d = S_UNLOCKED;
                exp_d   = 3'b000;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_UNLOCKED;
            exp_q   <= 3'b000;
            index_q <= 3'd0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            index_q <= index_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign locked = state_q == S_LOCKED;
    assign index  = index_q;
    assign wrap   = wrap_q;
    assign err    = err_q;

`ifdef SEQ_CHK_ERRCNT_EN
    logic [ERR_W-1:0] cnt_q, cnt_d;

    assign cnt_d = (err_d && cnt_q != {ERR_W{1'b1}}) ? cnt_q + ERR_W'(1) : cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign err_count = cnt_q;
`else
    assign err_count = '0;
`endif
endmodule

// File: tb/tb_seq_3bit_checker.sv
// tb_seq_3bit_checker: randomized scoreboard bench against a sequence-level reference model.
module tb_seq_3bit_checker;
    localparam int W   = 2;
    localparam int MAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [2:0]   code = 3'b000;
    logic         code_valid = 1'b0;
    logic         locked, wrap, err;
    logic [2:0]   index;
    logic [W-1:0] err_count;

    seq_3bit_checker #(.ERR_W(W)) dut (
        .clk(clk), .reset(reset), .code(code), .code_valid(code_valid),
        .locked(locked), .index(index), .wrap(wrap), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         l;
        logic [2:0]   idx;
        logic         w;
        logic         e;
        logic [W-1:0] c;
    } resp_t;

    resp_t q[$];
    resp_t m_exp_r, m_got_r;
    int tests = 0, fails = 0;
    int seq [5] = '{0, 4, 7, 2, 3};
    bit m_lock;
    int m_pos, m_idx, m_cnt;

    function automatic logic [W-1:0] cnt_view();
`ifdef SEQ_CHK_ERRCNT_EN
        return W'(m_cnt);
`else
        return '0;
`endif
    endfunction

    task automatic model_reset();
        m_lock = 0; m_pos = 0; m_idx = 0; m_cnt = 0;
    endtask

    // Reference: walk the ordinal position within the legal cycle.
    task automatic step(input logic v, input logic [2:0] c);
        bit w, e;
        @(negedge clk);
        code_valid = v;
        code = c;
        w = 0; e = 0;
        if (v) begin
            if (!m_lock) begin
                if (c == 0) begin m_lock = 1; m_idx = 0; m_pos = 1; end
            end else if (int'(c) == seq[m_pos]) begin
                m_idx = m_pos;
                w = (m_pos == 4);
                m_pos = (m_pos + 1) % 5;
            end else if (c == 0) begin
                e = 1; m_idx = 0; m_pos = 1;
            end else begin
                e = 1; m_lock = 0;
            end
            if (e && m_cnt < MAX) m_cnt++;
        end
        q.push_back('{m_lock, 3'(m_idx), w, e, cnt_view()});
    endtask

    task automatic chk_reset_state(input string name);
        tests++;
        if ({locked, index, wrap, err, err_count} !== '0) begin
            fails++;
            $display("FAIL %s: got locked=%0b index=%0d wrap=%0b err=%0b err_count=%0d, want all 0",
                     name, locked, index, wrap, err, err_count);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        code_valid = 1'b1;
        code = 3'b000;
        #2 reset = 1'b1;
        model_reset();
        #1 chk_reset_state("async_reset");
        @(negedge clk);
        chk_reset_state("reset_held_ignores_input");
        code_valid = 1'b0;
        reset = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (!reset && q.size() > 0) begin
            m_exp_r = q.pop_front();
            m_got_r = '{locked, index, wrap, err, err_count};
            tests++;
            if (m_got_r !== m_exp_r) begin
                fails++;
                $display("FAIL resp t=%0t: got l=%0b idx=%0d w=%0b e=%0b cnt=%0d want l=%0b idx=%0d w=%0b e=%0b cnt=%0d",
                         $time, m_got_r.l, m_got_r.idx, m_got_r.w, m_got_r.e, m_got_r.c,
                         m_exp_r.l, m_exp_r.idx, m_exp_r.w, m_exp_r.e, m_exp_r.c);
            end
        end
    end

    initial begin
        model_reset();
        #3 chk_reset_state("power_on_reset");
        @(negedge clk);
        reset = 1'b0;
        // full cycle then skip violation
        step(1, 3'b000); step(1, 3'b100); step(1, 3'b111); step(1, 3'b010);
        step(1, 3'b011); step(1, 3'b000);
        step(1, 3'b100); step(1, 3'b010);
        // ignored codes while unlocked, then relock
        step(1, 3'b101); step(1, 3'b111); step(1, 3'b011); step(1, 3'b000);
        // resync on 000 mid-sequence
        step(1, 3'b100); step(1, 3'b111); step(1, 3'b000); step(1, 3'b100);
        // idle cycles with junk code, then complete
        step(1, 3'b111); step(1, 3'b010);
        repeat (5) step(0, 3'($urandom_range(0, 7)));
        step(1, 3'b011);
        // counter saturation
        do_reset();
        repeat (5) begin
            step(1, 3'b000);
            step(1, 3'b101);
        end
        step(1, 3'b000); step(1, 3'b100);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] c;
            c = ($urandom_range(0, 9) < 6) ? (m_lock ? 3'(seq[m_pos]) : 3'b000)
                                           : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) do_reset();
            else step($urandom_range(0, 9) < 8, c);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending responses, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
